module_sum_entry: RTL and testbench

Keypad-driven operand entry and addition FSM sitting directly upstream of the seven-segment display controller. Consumes debounced key pulses, builds two decimal operands digit by digit, adds them, and hands the sum to the display controller through its `result_in` / `result_valid_in` / `busy` handshake. Holds the last result stable until the next transfer.

---
 rtl/module_sum_entry_if.sv | 31 +++
 rtl/module_sum_entry.sv | 213 +++++++++++++++++++++
 tb/tb_module_sum_entry.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/module_sum_entry_if.sv
// Keypad/display bundle for module_sum_entry.
// Handshakes carried here:
//   key side    : key_valid_in is a one-cycle pulse; the key is consumed only if
//                 key_ready_out is high in that same cycle, otherwise it is lost
//                 (the keypad never holds or retries a key).
//   display side: result_valid_out is a one-cycle pulse qualifying result_out; it is
//                 only issued while disp_busy_in is low, and disp_busy_in then rises
//                 and falls while the display consumes the value.
interface module_sum_entry_if #(
   parameter int RESULT_WIDTH = 14
);
   logic                    key_valid_in;
   logic [3:0]              key_code_in;
   logic                    disp_busy_in;
   logic [RESULT_WIDTH-1:0] result_out;
   logic                    result_valid_out;
   logic                    key_ready_out;
   logic [2:0]              state_out;

   // Keypad + display side
   modport master (
      output key_valid_in, key_code_in, disp_busy_in,
      input  result_out, result_valid_out, key_ready_out, state_out
   );

   // Entry/adder side
   modport slave (
      input  key_valid_in, key_code_in, disp_busy_in,
      output result_out, result_valid_out, key_ready_out, state_out
   );
endinterface

// File: rtl/module_sum_entry.sv
// Two-operand decimal keypad entry and adder feeding the seven-segment display
// controller. Operands are built digit by digit, added, and the sum is handed to
// the display with a valid pulse followed by a busy rise/fall handshake.
// Optional feature macro: SUM_OPERAND_ECHO_EN -- echoes each operand to the display
// while it is being typed (deferred through a single pending slot while busy).
module module_sum_entry #(
   parameter int DIGITS_PER_OPERAND = 3,
   parameter int RESULT_WIDTH       = 14,
   parameter int BUSY_TIMEOUT       = 2048
) (
   input logic               clk,
   input logic               rst,
   module_sum_entry_if.slave bus
);

   localparam logic [2:0] S_A       = 3'd0;
   localparam logic [2:0] S_B       = 3'd1;
   localparam logic [2:0] S_SUM     = 3'd2;
   localparam logic [2:0] S_SEND    = 3'd3;
   localparam logic [2:0] S_WAIT_HI = 3'd4;
   localparam logic [2:0] S_WAIT_LO = 3'd5;
   localparam logic [2:0] S_DONE    = 3'd6;

   localparam logic [3:0] KEY_ENTER = 4'hA;
   localparam logic [3:0] KEY_CLEAR = 4'hC;

   localparam int CNT_W = $clog2(DIGITS_PER_OPERAND + 1);
   localparam int TO_W  = $clog2(BUSY_TIMEOUT + 1);

   logic [2:0]              state_q, state_d;
   logic [RESULT_WIDTH-1:0] op_a_q, op_a_d;
   logic [RESULT_WIDTH-1:0] op_b_q, op_b_d;
   logic [RESULT_WIDTH-1:0] sum_q, sum_d;
   logic [CNT_W-1:0]        digit_cnt_q, digit_cnt_d;
   logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
   logic [RESULT_WIDTH-1:0] result_q, result_d;
   logic                    result_valid_q, result_valid_d;

   logic                    key_ready;
   logic                    key_take;
   logic                    is_digit;
   logic                    digit_room;
   logic                    timeout_hit;
   logic [RESULT_WIDTH-1:0] digit_ext;
   logic [RESULT_WIDTH-1:0] cur_op;
   logic [RESULT_WIDTH-1:0] acc_op;

`ifdef SUM_OPERAND_ECHO_EN
   logic                    echo_pend_q, echo_pend_d;
   logic [RESULT_WIDTH-1:0] echo_val_q, echo_val_d;
   logic                    echo_req;
`endif

   // Key decode, operand accumulation and the entry/handshake state machine
   always_comb begin
      state_d        = state_q;
      op_a_d         = op_a_q;
      op_b_d         = op_b_q;
      sum_d          = sum_q;
      digit_cnt_d    = digit_cnt_q;
      to_cnt_d       = to_cnt_q;
      result_d       = result_q;
      result_valid_d = 1'b0;

      key_ready   = (state_q == S_A) || (state_q == S_B) || (state_q == S_DONE);
      key_take    = bus.key_valid_in && key_ready;
      is_digit    = (bus.key_code_in <= 4'd9);
      digit_room  = (digit_cnt_q < CNT_W'(DIGITS_PER_OPERAND));
      timeout_hit = (to_cnt_q == TO_W'(BUSY_TIMEOUT - 1));
      digit_ext   = RESULT_WIDTH'(bus.key_code_in);
      cur_op      = (state_q == S_B) ? op_b_q : op_a_q;
      // op*10 + digit without a multiplier
      acc_op      = (cur_op << 3) + (cur_op << 1) + digit_ext;

      case (state_q)
         S_A, S_B: begin
            if (key_take) begin
               if (is_digit) begin
                  if (digit_room) begin
                     if (state_q == S_A) op_a_d = acc_op;
                     else                op_b_d = acc_op;
                     digit_cnt_d = digit_cnt_q + CNT_W'(1);
                  end
               end else if (bus.key_code_in == KEY_ENTER) begin
                  if (state_q == S_A) begin
                     state_d     = S_B;
                     digit_cnt_d = '0;
                  end else begin
                     state_d = S_SUM;
                  end
               end else if (bus.key_code_in == KEY_CLEAR) begin
                  op_a_d      = '0;
                  op_b_d      = '0;
                  digit_cnt_d = '0;
                  state_d     = S_A;
               end
            end
         end
         S_SUM: begin
            sum_d   = op_a_q + op_b_q;
            state_d = S_SEND;
         end
         S_SEND: begin
            // never start a transfer on top of a busy display
            if (!bus.disp_busy_in) begin
               result_d       = sum_q;
               result_valid_d = 1'b1;
               to_cnt_d       = '0;
               state_d        = S_WAIT_HI;
            end
         end
         S_WAIT_HI: begin
            if (bus.disp_busy_in) begin
               to_cnt_d = '0;
               state_d  = S_WAIT_LO;
            end else if (timeout_hit) begin
               state_d = S_DONE;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         S_WAIT_LO: begin
            if (!bus.disp_busy_in || timeout_hit) begin
               state_d = S_DONE;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         S_DONE: begin
            if (key_take) begin
               if (is_digit) begin
                  // first digit of a fresh calculation
                  op_a_d      = digit_ext;
                  op_b_d      = '0;
                  digit_cnt_d = CNT_W'(1);
                  state_d     = S_A;
               end else if (bus.key_code_in == KEY_CLEAR) begin
                  op_a_d      = '0;
                  op_b_d      = '0;
                  digit_cnt_d = '0;
                  state_d     = S_A;
               end
            end
         end
         default: state_d = S_A;
      endcase

`ifdef SUM_OPERAND_ECHO_EN
      // An echo is due on every accepted digit and on every entry into S_B; only
      // the newest operand value is kept while the display is busy.
      echo_req = key_take && (
                    (((state_q == S_A) || (state_q == S_B)) && is_digit && digit_room) ||
                    ((state_q == S_A) && (bus.key_code_in == KEY_ENTER)) ||
                    ((state_q == S_DONE) && is_digit));
      echo_pend_d = echo_pend_q;
      echo_val_d  = echo_val_q;
      if (echo_req) begin
         echo_pend_d = 1'b1;
         echo_val_d  = (state_d == S_B) ? op_b_d : op_a_d;
      end
      if (state_q == S_SEND) begin
         // the sum supersedes any operand still waiting to be shown
         echo_pend_d = 1'b0;
      end else if (echo_pend_d && !bus.disp_busy_in) begin
         result_d       = echo_val_d;
         result_valid_d = 1'b1;
         echo_pend_d    = 1'b0;
      end
`endif
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_A;
         op_a_q         <= '0;
         op_b_q         <= '0;
         sum_q          <= '0;
         digit_cnt_q    <= '0;
         to_cnt_q       <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         op_a_q         <= op_a_d;
         op_b_q         <= op_b_d;
         sum_q          <= sum_d;
         digit_cnt_q    <= digit_cnt_d;
         to_cnt_q       <= to_cnt_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
      end
   end

`ifdef SUM_OPERAND_ECHO_EN
   // Pending operand echo
   always_ff @(posedge clk) begin
      if (rst) begin
         echo_pend_q <= 1'b0;
         echo_val_q  <= '0;
      end else begin
         echo_pend_q <= echo_pend_d;
         echo_val_q  <= echo_val_d;
      end
   end
`endif

   assign bus.result_out       = result_q;
   assign bus.result_valid_out = result_valid_q;
   assign bus.key_ready_out    = key_ready;
   assign bus.state_out        = state_q;

endmodule

// File: tb/tb_module_sum_entry.sv
// Bench for module_sum_entry: directed sequences plus randomized operand entry,
// a display model that answers each valid pulse with a 10-cycle busy, and a
// scoreboard of expected transferred values.
module tb_module_sum_entry;

   localparam int RW = 14;
`ifdef SUM_OPERAND_ECHO_EN
   localparam int GAP = 14;
`else
   localparam int GAP = 2;
`endif

   logic clk;
   logic rst;
   logic busy_auto;
   logic busy_force;
   bit   disp_auto;

   int n_checks;
   int n_fail;
   int n_pulses;
   int exp_pulses;
   logic [RW-1:0] exp_q[$];
   logic [RW-1:0] last_result;

   // reference model: phase 0 = typing A, 1 = typing B, 2 = result shown
   int          m_phase;
   int unsigned m_a, m_b, m_cnt;

   module_sum_entry_if #(.RESULT_WIDTH(RW)) bus ();

   module_sum_entry #(
      .DIGITS_PER_OPERAND(3),
      .RESULT_WIDTH(RW),
      .BUSY_TIMEOUT(2048)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   assign bus.disp_busy_in = busy_auto | busy_force;

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int unsigned v);
      exp_q.push_back(RW'(v));
      exp_pulses++;
   endtask

   task automatic model_reset();
      m_phase = 0; m_a = 0; m_b = 0; m_cnt = 0;
   endtask

   task automatic model_key(input logic [3:0] c);
      if (c <= 4'd9) begin
         if (m_phase == 2) begin
            m_a = c; m_b = 0; m_cnt = 1; m_phase = 0;
`ifdef SUM_OPERAND_ECHO_EN
            push_exp(m_a);
`endif
         end else if (m_cnt < 3) begin
            if (m_phase == 0) m_a = m_a * 10 + c;
            else              m_b = m_b * 10 + c;
            m_cnt++;
`ifdef SUM_OPERAND_ECHO_EN
            push_exp(m_phase == 0 ? m_a : m_b);
`endif
         end
      end else if (c == 4'hA) begin
         if (m_phase == 0) begin
            m_phase = 1; m_cnt = 0;
`ifdef SUM_OPERAND_ECHO_EN
            push_exp(m_b);
`endif
         end else if (m_phase == 1) begin
            push_exp(m_a + m_b);
            m_phase = 2;
         end
      end else if (c == 4'hC) begin
         model_reset();
      end
   endtask

   // one key pulse; returns at the falling edge right after the sampling edge
   task automatic press(input logic [3:0] c, input bit to_model, input int gap);
      repeat (gap) @(negedge clk);
      if (to_model) model_key(c);
      bus.key_valid_in = 1'b1;
      bus.key_code_in  = c;
      @(negedge clk);
      bus.key_valid_in = 1'b0;
      bus.key_code_in  = 4'h0;
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
      int n = 0;
      while (bus.state_out !== s && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check(tag, 32'(bus.state_out), 32'(s));
   endtask

   // display model: busy rises one cycle after a valid pulse and stays 10 cycles
   initial begin
      busy_auto = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (bus.result_valid_out && disp_auto && !rst) begin
            @(posedge clk); #1;
            busy_auto = 1'b1;
            repeat (10) begin
               @(posedge clk); #1;
            end
            busy_auto = 1'b0;
         end
      end
   end

   // scoreboard: every pulse must carry the next expected value, and result_out
   // must not move between pulses
   initial begin
      last_result = '0;
      forever begin
         @(posedge clk); #1;
         if (rst) begin
            last_result = '0;
         end else if (bus.result_valid_out === 1'b1) begin
            n_pulses++;
            check("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("pulse_value", 32'(bus.result_out), 32'(exp_q.pop_front()));
            last_result = bus.result_out;
         end else begin
            if (bus.result_out !== last_result) check("result_hold", 32'(bus.result_out), 32'(last_result));
         end
      end
   end

   initial begin
      int base;
      int cyc;
      n_checks = 0; n_fail = 0; n_pulses = 0; exp_pulses = 0;
      disp_auto = 1'b1;
      busy_force = 1'b0;
      bus.key_valid_in = 1'b0;
      bus.key_code_in  = 4'h0;
      model_reset();

      // reset
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_state", 32'(bus.state_out), 32'd0);
      check("rst_result", 32'(bus.result_out), 32'd0);
      check("rst_valid", 32'(bus.result_valid_out), 32'd0);
      check("rst_ready", 32'(bus.key_ready_out), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // 12 + 34 with cycle-exact transfer timing
      press(4'h1, 1, GAP); press(4'h2, 1, GAP); press(4'hA, 1, GAP);
      press(4'h3, 1, GAP); press(4'h4, 1, GAP);
      base = n_pulses;
      press(4'hA, 1, GAP);
      check("t_sum_state", 32'(bus.state_out), 32'd2);
      @(posedge clk); #1;
      check("t_send_state", 32'(bus.state_out), 32'd3);
      check("t_send_novalid", 32'(bus.result_valid_out), 32'd0);
      @(posedge clk); #1;
      check("t_valid_hi", 32'(bus.result_valid_out), 32'd1);
      check("t_result_46", 32'(bus.result_out), 32'd46);
      check("t_ready_lo", 32'(bus.key_ready_out), 32'd0);
      @(posedge clk); #1;
      check("t_valid_lo", 32'(bus.result_valid_out), 32'd0);
      wait_state(3'd6, 100, "t_done");
      check("t_one_pulse", 32'(n_pulses - base), 32'(exp_pulses - base));
      check("t_ready_done", 32'(bus.key_ready_out), 32'd1);

      // enter in S_DONE is ignored
      press(4'hA, 1, GAP);
      repeat (2) @(posedge clk); #1;
      check("done_enter_ignored", 32'(bus.state_out), 32'd6);

      // 999 + 999, no truncation (digit from S_DONE starts operand A)
      press(4'h9, 1, GAP);
      check("done_digit_to_a", 32'(bus.state_out), 32'd0);
      press(4'h9, 1, GAP); press(4'h9, 1, GAP); press(4'hA, 1, GAP);
      press(4'h9, 1, GAP); press(4'h9, 1, GAP); press(4'h9, 1, GAP); press(4'hA, 1, GAP);
      wait_state(3'd6, 100, "max_done");
      check("max_result", 32'(bus.result_out), 32'd1998);

      // fourth digit dropped: 123 + 5
      press(4'h1, 1, GAP); press(4'h2, 1, GAP); press(4'h3, 1, GAP); press(4'h4, 1, GAP);
      press(4'hA, 1, GAP); press(4'h5, 1, GAP); press(4'hA, 1, GAP);
      wait_state(3'd6, 100, "drop_done");
      check("drop_result", 32'(bus.result_out), 32'd128);

      // clear discards A; result_out holds until the next transfer
      press(4'h7, 1, GAP); press(4'hC, 1, GAP);
      check("clear_state", 32'(bus.state_out), 32'd0);
      press(4'h5, 1, GAP); press(4'hA, 1, GAP);
      check("clear_hold", 32'(bus.result_out), 32'd128);
      press(4'hA, 1, GAP);
      wait_state(3'd6, 100, "clear_done");
      check("clear_result", 32'(bus.result_out), 32'd5);

      // S_SEND stalls while busy; keys during the handshake are dropped
      press(4'h2, 1, GAP); press(4'hA, 1, GAP); press(4'h3, 1, GAP);
      busy_force = 1'b1;
      press(4'hA, 1, GAP);
      repeat (6) @(posedge clk);
      #1;
      check("stall_state", 32'(bus.state_out), 32'd3);
      check("stall_novalid", 32'(bus.result_valid_out), 32'd0);
      @(negedge clk);
      busy_force = 1'b0;
      @(posedge clk); #1;
      check("stall_release_valid", 32'(bus.result_valid_out), 32'd1);
      check("stall_result", 32'(bus.result_out), 32'd5);
      @(posedge clk); #1;
      check("hs_ready_lo", 32'(bus.key_ready_out), 32'd0);
      press(4'h9, 0, 0);
      press(4'hC, 0, 0);
      wait_state(3'd6, 100, "hs_done");
      press(4'h2, 1, GAP); press(4'hA, 1, GAP); press(4'h2, 1, GAP); press(4'hA, 1, GAP);
      wait_state(3'd6, 100, "hs_after_done");
      check("hs_after_result", 32'(bus.result_out), 32'd4);

      // busy never rises: exactly 2048 cycles in S_WAIT_HI
      disp_auto = 1'b0;
      press(4'h1, 1, GAP); press(4'hA, 1, GAP); press(4'h1, 1, GAP); press(4'hA, 1, GAP);
      wait_state(3'd4, 20, "to_enter_wait");
      cyc = 0;
      while (bus.state_out === 3'd4 && cyc < 3000) begin
         cyc++;
         @(posedge clk); #1;
      end
      check("to_cycles", 32'(cyc), 32'd2048);
      check("to_done", 32'(bus.state_out), 32'd6);
      disp_auto = 1'b1;

`ifdef SUM_OPERAND_ECHO_EN
      // echo: 4 then 42, the second one deferred until busy falls
      press(4'hC, 1, GAP);
      base = n_pulses;
      press(4'h4, 1, GAP);
      press(4'h2, 1, 2);
      repeat (20) @(posedge clk);
      #1;
      check("echo_pulses", 32'(n_pulses - base), 32'd2);
      check("echo_result", 32'(bus.result_out), 32'd42);
      press(4'hA, 1, GAP); press(4'hA, 1, GAP);
      wait_state(3'd6, 100, "echo_done");
`endif

      // randomized calculations
      for (int r = 0; r < 20; r++) begin
         int na, nb;
         na = $urandom_range(0, 4);
         nb = $urandom_range(0, 4);
         press(4'hC, 1, GAP);
         for (int i = 0; i < na; i++) press(4'($urandom_range(0, 9)), 1, GAP);
         if ($urandom_range(0, 3) == 0) press(4'hF, 1, GAP);
         press(4'hA, 1, GAP);
         for (int i = 0; i < nb; i++) press(4'($urandom_range(0, 9)), 1, GAP);
         press(4'hA, 1, GAP);
         wait_state(3'd6, 100, "rand_done");
      end

      // reset while the sum is being formed: no pulse afterwards
      press(4'h1, 1, GAP); press(4'hA, 1, GAP); press(4'h2, 1, GAP);
      press(4'hA, 1, GAP);
      rst = 1'b1;
      base = n_pulses;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      exp_pulses = n_pulses;
      model_reset();
      repeat (20) @(posedge clk);
      #1;
      check("abort_no_pulse", 32'(n_pulses - base), 32'd0);
      check("abort_state", 32'(bus.state_out), 32'd0);
      check("abort_result", 32'(bus.result_out), 32'd0);

      check("pulse_total", 32'(n_pulses), 32'(exp_pulses));
      check("exp_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
